// File: rtl/btn_event_gen.sv
// ============================================================================
// Module   : btn_event_gen
// Brief    : Per-channel button debounce with press/release/click/long/repeat events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_event_gen #(
    parameter int N_BTN         = 3,
    parameter int DEB_CYCLES    = 1000000,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] click_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] repeat_o
);

    localparam int DEB_W  = $clog2(DEB_CYCLES) + 1;
    localparam int LONG_W = $clog2(LONG_CYCLES) + 1;
    localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

    // Terminal counts are one less than the period: the event fires on the
    // edge where the counter would otherwise reach the full count.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } hold_state_t;

    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        logic [1:0]        sync;
        logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
        logic              level, level_nxt;
        logic              rise, fall;
        hold_state_t       state, state_nxt;
        logic [LONG_W-1:0] hold_cnt, hold_cnt_nxt;
        logic [REP_W-1:0]  rep_cnt, rep_cnt_nxt;
        logic              click_nxt, long_nxt, repeat_nxt;
        logic              press_r, release_r, click_r, long_r, repeat_r;

        always_comb begin
            deb_cnt_nxt = '0;
            level_nxt   = level;
            rise        = 1'b0;
            fall        = 1'b0;
            if (sync[1] != level) begin
                if (deb_cnt >= DEB_LAST) begin
                    level_nxt = ~level;
                    rise      = ~level;
                    fall      = level;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                end
            end
        end

        // Release has priority over a long/repeat due on the same edge.
        always_comb begin
            state_nxt    = state;
            hold_cnt_nxt = hold_cnt;
            rep_cnt_nxt  = rep_cnt;
            click_nxt    = 1'b0;
            long_nxt     = 1'b0;
            repeat_nxt   = 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt    = DOWN;
                        hold_cnt_nxt = '0;
                    end
                end
                DOWN: begin
                    if (fall) begin
                        state_nxt = IDLE;
                        click_nxt = 1'b1;
                    end else if (hold_cnt >= LONG_LAST) begin
                        state_nxt   = LONG;
                        long_nxt    = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_nxt = IDLE;
                    end else if (rep_cnt >= REP_LAST) begin
                        repeat_nxt  = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync      <= '0;
                deb_cnt   <= '0;
                level     <= 1'b0;
                state     <= IDLE;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                click_r   <= 1'b0;
                long_r    <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                sync      <= {sync[0], btn_i[k]};
                deb_cnt   <= deb_cnt_nxt;
                level     <= level_nxt;
                state     <= state_nxt;
                hold_cnt  <= hold_cnt_nxt;
                rep_cnt   <= rep_cnt_nxt;
                press_r   <= rise;
                release_r <= fall;
                click_r   <= click_nxt;
                long_r    <= long_nxt;
                repeat_r  <= repeat_nxt;
            end
        end

        assign level_o[k]   = level;
        assign press_o[k]   = press_r;
        assign release_o[k] = release_r;
        assign click_o[k]   = click_r;
        assign long_o[k]    = long_r;
        assign repeat_o[k]  = repeat_r;
    end

endmodule

`default_nettype wire
